// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer for the single-bit accumulator core: program store, run/step/halt/clear, instruction counter.
// Define CPU_RUN_CTRL_BP_EN to build the address breakpoint (hit logic, skip flag, BRK state).
module cpu_run_ctrl #(
  parameter int AW    = 4,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  input  logic             prog_we,
  input  logic [AW-1:0]    prog_addr,
  input  logic             prog_wdata,
  output logic             prog_err,
  input  logic             bp_en,
  input  logic [AW-1:0]    bp_addr,
  input  logic [AW-1:0]    core_addr,
  output logic             core_data,
  output logic             core_ce,
  output logic             core_rst,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] exec_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2,
    S_BRK  = 2'd3
  } state_t;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_RUN   = 2'b01;
  localparam logic [1:0] OP_STEP  = 2'b10;
  localparam logic [1:0] OP_HALT  = 2'b11;

  state_t              st_q, st_d;
  logic                clr_q;
  logic                err_q;
  logic [2**AW-1:0]    prog_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                accept;
  logic                do_clear;
  logic                wr_ok;
  logic                hit;

  assign accept   = cmd_valid && cmd_ready;
  assign do_clear = accept && (cmd_op == OP_CLEAR);
  // Writes are legal only while the core is not executing, judged on the pre-transition state.
  assign wr_ok    = (st_q == S_IDLE) || (st_q == S_BRK);

`ifdef CPU_RUN_CTRL_BP_EN
  logic skip_q, skip_d;

  assign hit = (st_q == S_RUN) && bp_en && (core_addr == bp_addr) && !skip_q;

  // skip lets a resumed run execute the breakpoint instruction once before re-arming.
  always_comb begin
    skip_d = skip_q;
    if (core_ce)
      skip_d = 1'b0;
    if (accept && (st_q == S_BRK) && (cmd_op == OP_RUN))
      skip_d = 1'b1;
    if (accept && ((cmd_op == OP_HALT) || (cmd_op == OP_CLEAR)))
      skip_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST)
      skip_q <= 1'b0;
    else
      skip_q <= skip_d;
  end
`else
  logic unused_bp;
  assign unused_bp = ^{bp_en, bp_addr};
  assign hit       = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q   <= S_IDLE;
      clr_q  <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= '0;
      prog_q <= '0;
    end else begin
      st_q  <= st_d;
      clr_q <= do_clear;
      err_q <= prog_we && !wr_ok;
      if (prog_we && wr_ok)
        prog_q[prog_addr] <= prog_wdata;
      if (do_clear)
        cnt_q <= '0;
      else if (core_ce && (cnt_q != '1))
        cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      S_IDLE: begin
        if (accept && (cmd_op == OP_RUN))
          st_d = S_RUN;
        else if (accept && (cmd_op == OP_STEP))
          st_d = S_STEP;
      end
      S_RUN: begin
        // HALT outranks a breakpoint hit in the same cycle.
        if (accept && (cmd_op == OP_HALT))
          st_d = S_IDLE;
        else if (hit)
          st_d = S_BRK;
      end
      S_STEP: st_d = S_IDLE;
      S_BRK: begin
        if (accept && (cmd_op == OP_RUN))
          st_d = S_RUN;
        else if (accept && (cmd_op == OP_STEP))
          st_d = S_STEP;
        else if (accept && (cmd_op == OP_HALT))
          st_d = S_IDLE;
      end
      default: st_d = S_IDLE;
    endcase
    if (do_clear)
      st_d = S_IDLE;
  end

  always_comb begin
    state     = st_q;
    cmd_ready = (st_q != S_STEP);
    core_ce   = ((st_q == S_RUN) && !hit) || (st_q == S_STEP);
    core_rst  = RST || clr_q;
  end

  assign core_data = prog_q[core_addr];
  assign prog_err  = err_q;
  assign exec_cnt  = cnt_q;

endmodule
